dmem_access_unit: RTL and testbench

- Memory-side responder to the control unit's data-memory and address-stepping strobes (dmem_read, dmem_write, mar_inc, col_inc, row_inc, col_zero).
- Owns the MAR, row and column counters, and the MDR.
- Sequences synchronous data-memory read/write transactions with configurable read latency.
- Sits between the control unit / datapath and the data RAM.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/wrap_counter.sv | 30 +++
 rtl/dmem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_dmem_access_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access unit.
// Holds the FSM state encoding, default widths and error bit positions.
package dmem_pkg;

    localparam int BUS_W_DEF  = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int ROW_W_DEF  = 8;
    localparam int COL_W_DEF  = 8;
    localparam int LAT_W      = 2;

    // err is the OR of these sticky causes
    localparam int ERR_W    = 2;
    localparam int ERR_BUSY = 0;
    localparam int ERR_RDWR = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAP  = 2'd2,
        WR      = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with synchronous clear; clr has priority over inc.
// Used for the row and column address counters.
module wrap_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: address counters, MDR and the RAM
// read/write sequencer driven by the control unit's strobes.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ROW_W     = ROW_W_DEF,
    parameter int COL_W     = COL_W_DEF,
    parameter int N_ROWS    = 256,
    parameter int N_COLS    = 256,
    parameter int MEM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 mar_inc,
    input  logic                 col_inc,
    input  logic                 row_inc,
    input  logic                 col_zero,
    input  logic [BUS_WIDTH-1:0] wr_data,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    output logic [BUS_WIDTH-1:0] mdr,
    output logic                 rd_valid,
    output logic                 busy,
    output logic [ROW_W-1:0]     row,
    output logic [COL_W-1:0]     col,
    output logic [ADDR_W-1:0]    mar,
    output logic                 err
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    dmem_state_e          state_q, state_n;
    logic [LAT_W-1:0]     cnt_q, cnt_n;
    logic [ERR_W-1:0]     err_q, err_n;
    logic [ADDR_W-1:0]    addr_n;
    logic                 en_n, we_n, rdv_n;
    logic [BUS_WIDTH-1:0] wdata_n, mdr_n;
    logic                 rd_prev, wr_prev;
    logic                 rd_edge, wr_edge;

    assign rd_edge = dmem_read & ~rd_prev;
    assign wr_edge = dmem_write & ~wr_prev;
    assign busy    = (state_q != IDLE);
    assign err     = |err_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        addr_n  = mem_addr;
        en_n    = mem_en;
        we_n    = mem_we;
        wdata_n = mem_wdata;
        mdr_n   = mdr;
        rdv_n   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // write wins a tie; the dropped read is flagged
                if (wr_edge) begin
                    state_n = WR;
                    addr_n  = mar;
                    wdata_n = wr_data;
                    en_n    = 1'b1;
                    we_n    = 1'b1;
                    if (rd_edge) begin
                        err_n[ERR_RDWR] = 1'b1;
                    end
                end else if (rd_edge) begin
                    state_n = RD_WAIT;
                    addr_n  = mar;
                    en_n    = 1'b1;
                    we_n    = 1'b0;
                    cnt_n   = LAT_INIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_n = RD_CAP;
                end else begin
                    cnt_n = cnt_q - LAT_W'(1);
                end
            end
            RD_CAP: begin
                mdr_n   = mem_rdata;
                rdv_n   = 1'b1;
                en_n    = 1'b0;
                state_n = IDLE;
            end
            WR: begin
                en_n    = 1'b0;
                we_n    = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (busy && (rd_edge || wr_edge)) begin
            err_n[ERR_BUSY] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= '0;
            mem_addr  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mdr       <= '0;
            rd_valid  <= 1'b0;
            rd_prev   <= 1'b0;
            wr_prev   <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            err_q     <= err_n;
            mem_addr  <= addr_n;
            mem_en    <= en_n;
            mem_we    <= we_n;
            mem_wdata <= wdata_n;
            mdr       <= mdr_n;
            rd_valid  <= rdv_n;
            rd_prev   <= dmem_read;
            wr_prev   <= dmem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mar <= '0;
        end else if (mar_inc) begin
            mar <= mar + ADDR_W'(1);
        end
    end

    wrap_counter #(
        .WIDTH   (ROW_W),
        .MODULUS (N_ROWS)
    ) u_row (
        .clk   (clk),
        .reset (reset),
        .inc   (row_inc),
        .clr   (1'b0),
        .count (row)
    );

    wrap_counter #(
        .WIDTH   (COL_W),
        .MODULUS (N_COLS)
    ) u_col (
        .clk   (clk),
        .reset (reset),
        .inc   (col_inc),
        .clr   (col_zero),
        .count (col)
    );

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench: one unit with 1-cycle RAM latency and 4 columns,
// one with 3-cycle latency, both fed the same strobe sequence.
module tb_dmem_access_unit;

    logic        clk;
    logic        reset;
    logic        dmem_read, dmem_write;
    logic        mar_inc, col_inc, row_inc, col_zero;
    logic [15:0] wr_data;

    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    logic [15:0] a_addr, a_wdata, a_mdr, a_rdata, a_mar;
    logic        a_en, a_we, a_rdv, a_busy, a_err;
    logic [7:0]  a_row, a_col;

    logic [15:0] b_addr, b_wdata, b_mdr, b_rdata, b_mar;
    logic        b_en, b_we, b_rdv, b_busy, b_err;
    logic [7:0]  b_row, b_col;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] pb0, pb1, pb2;

    int total = 0;
    int bad   = 0;
    int nwe;
    int nrv;
    logic [7:0] cseq [4];

    dmem_access_unit #(
        .MEM_LAT (1),
        .N_COLS  (4)
    ) u_a (
        .clk        (clk),
        .reset      (reset),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .mar_inc    (mar_inc),
        .col_inc    (col_inc),
        .row_inc    (row_inc),
        .col_zero   (col_zero),
        .wr_data    (wr_data),
        .mem_rdata  (a_rdata),
        .mem_addr   (a_addr),
        .mem_en     (a_en),
        .mem_we     (a_we),
        .mem_wdata  (a_wdata),
        .mdr        (a_mdr),
        .rd_valid   (a_rdv),
        .busy       (a_busy),
        .row        (a_row),
        .col        (a_col),
        .mar        (a_mar),
        .err        (a_err)
    );

    dmem_access_unit #(
        .MEM_LAT (3)
    ) u_b (
        .clk        (clk),
        .reset      (reset),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .mar_inc    (mar_inc),
        .col_inc    (col_inc),
        .row_inc    (row_inc),
        .col_zero   (col_zero),
        .wr_data    (wr_data),
        .mem_rdata  (b_rdata),
        .mem_addr   (b_addr),
        .mem_en     (b_en),
        .mem_we     (b_we),
        .mem_wdata  (b_wdata),
        .mdr        (b_mdr),
        .rd_valid   (b_rdv),
        .busy       (b_busy),
        .row        (b_row),
        .col        (b_col),
        .mar        (b_mar),
        .err        (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: read data appears MEM_LAT edges after mem_en is sampled
    always @(posedge clk) begin
        if (pre_we) begin
            mem_a[pre_addr] <= pre_data;
        end else if (a_en && a_we) begin
            mem_a[a_addr[7:0]] <= a_wdata;
        end
        a_rdata <= (a_en && !a_we) ? mem_a[a_addr[7:0]] : 16'h0;
    end

    always @(posedge clk) begin
        if (pre_we) begin
            mem_b[pre_addr] <= pre_data;
        end else if (b_en && b_we) begin
            mem_b[b_addr[7:0]] <= b_wdata;
        end
        pb0 <= (b_en && !b_we) ? mem_b[b_addr[7:0]] : 16'h0;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign b_rdata = pb2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        cseq = '{8'd1, 8'd2, 8'd3, 8'd0};
        reset = 1'b1;
        dmem_read = 1'b0;
        dmem_write = 1'b0;
        mar_inc = 1'b0;
        col_inc = 1'b0;
        row_inc = 1'b0;
        col_zero = 1'b0;
        wr_data = 16'h0;
        pre_we = 1'b0;
        pre_addr = 8'h0;
        pre_data = 16'h0;
        repeat (2) @(negedge clk);

        chk("rst_addr", a_addr, 0);
        chk("rst_en", a_en, 0);
        chk("rst_we", a_we, 0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_mdr", a_mdr, 0);
        chk("rst_rdv", a_rdv, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_err", a_err, 0);
        chk("rst_mar", a_mar, 0);
        chk("rst_row", a_row, 0);
        chk("rst_col", a_col, 0);
        chk("rst_b_busy", b_busy, 0);

        reset = 1'b0;
        pre_we = 1'b1;
        pre_addr = 8'd5;
        pre_data = 16'hBEEF;
        @(negedge clk);
        pre_we = 1'b0;

        mar_inc = 1'b1;
        repeat (5) @(negedge clk);
        mar_inc = 1'b0;
        chk("mar5", a_mar, 5);

        dmem_read = 1'b1;
        @(negedge clk);
        dmem_read = 1'b0;
        chk("rd1_en", a_en, 1);
        chk("rd1_addr", a_addr, 5);
        chk("rd1_busy", a_busy, 1);
        chk("rd1_rdv", a_rdv, 0);
        @(negedge clk);
        chk("rd2_en", a_en, 1);
        chk("rd2_addr", a_addr, 5);
        chk("rd2_rdv", a_rdv, 0);
        @(negedge clk);
        chk("rd3_rdv", a_rdv, 1);
        chk("rd3_mdr", a_mdr, 16'hBEEF);
        chk("rd3_en", a_en, 0);
        chk("rd3_busy", a_busy, 0);
        @(negedge clk);
        chk("rd4_rdv", a_rdv, 0);
        chk("rd4_mdr", a_mdr, 16'hBEEF);
        repeat (3) @(negedge clk);

        mar_inc = 1'b1;
        repeat (2) @(negedge clk);
        mar_inc = 1'b0;
        chk("mar7", a_mar, 7);
        wr_data = 16'h1234;
        dmem_write = 1'b1;
        nwe = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) dmem_write = 1'b0;
            if (a_we) begin
                nwe++;
                chk("wr_addr", a_addr, 7);
                chk("wr_data", a_wdata, 16'h1234);
                chk("wr_en", a_en, 1);
            end
        end
        chk("wr_once", nwe, 1);
        chk("wr_noerr", a_err, 0);

        dmem_read = 1'b1;
        @(negedge clk);
        dmem_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("rb_rdv", a_rdv, 1);
        chk("rb_mdr", a_mdr, 16'h1234);
        repeat (3) @(negedge clk);

        col_inc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("col_seq%0d", i), a_col, cseq[i]);
        end
        col_inc = 1'b0;
        col_inc = 1'b1;
        repeat (2) @(negedge clk);
        col_inc = 1'b0;
        chk("col2", a_col, 2);
        chk("row0", a_row, 0);
        row_inc = 1'b1;
        col_zero = 1'b1;
        @(negedge clk);
        row_inc = 1'b0;
        col_zero = 1'b0;
        chk("rz_row", a_row, 1);
        chk("rz_col", a_col, 0);
        col_inc = 1'b1;
        @(negedge clk);
        chk("col1", a_col, 1);
        col_zero = 1'b1;
        @(negedge clk);
        col_inc = 1'b0;
        col_zero = 1'b0;
        chk("cz_col", a_col, 0);

        dmem_read = 1'b1;
        @(negedge clk);
        chk("e_busy", b_busy, 1);
        dmem_write = 1'b1;
        @(negedge clk);
        dmem_read = 1'b0;
        dmem_write = 1'b0;
        chk("e_err", b_err, 1);
        chk("e_we", b_we, 0);
        repeat (2) @(negedge clk);
        chk("e_rdv_early", b_rdv, 0);
        chk("e_en_held", b_en, 1);
        @(negedge clk);
        chk("e_rdv", b_rdv, 1);
        chk("e_mdr", b_mdr, 16'h1234);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("r_err", b_err, 0);
        chk("r_mdr", b_mdr, 0);
        chk("r_mar", b_mar, 0);

        wr_data = 16'hA5A5;
        dmem_read = 1'b1;
        dmem_write = 1'b1;
        @(negedge clk);
        dmem_read = 1'b0;
        dmem_write = 1'b0;
        chk("rw_we", b_we, 1);
        chk("rw_en", b_en, 1);
        chk("rw_addr", b_addr, 0);
        chk("rw_wdata", b_wdata, 16'hA5A5);
        chk("rw_err", b_err, 1);
        @(negedge clk);
        chk("rw_en_off", b_en, 0);
        chk("rw_busy_off", b_busy, 0);
        nrv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (b_rdv) nrv++;
        end
        chk("rw_no_read", nrv, 0);

        dmem_read = 1'b1;
        @(negedge clk);
        dmem_read = 1'b0;
        @(negedge clk);
        chk("ab_busy_pre", b_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("ab_en", b_en, 0);
        chk("ab_busy", b_busy, 0);
        chk("ab_rdv", b_rdv, 0);
        chk("ab_mdr", b_mdr, 0);
        nrv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b_rdv) nrv++;
        end
        chk("ab_no_rdv", nrv, 0);
        chk("ab_mdr_end", b_mdr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
